// File: rtl/video_pkg.sv
// Shared video constants, mode encodings, colours and the box axis-step helper
// used by the pattern generator.
package video_pkg;

   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;
   localparam int BOX_SIZE    = 32;
   localparam int BOX_STEP    = 2;
   localparam int CHECK_SHIFT = 5;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_CHECK = 2'd1,
      MODE_GRAD  = 2'd2,
      MODE_BOX   = 2'd3
   } mode_e;

   localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
   localparam logic [23:0] COL_GREEN   = 24'h00FF00;
   localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] COL_RED     = 24'hFF0000;
   localparam logic [23:0] COL_BLUE    = 24'h0000FF;
   localparam logic [23:0] COL_BLACK   = 24'h000000;
   localparam logic [23:0] COL_BOX_BG  = 24'h000040;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = COL_WHITE;
         3'd1:    c = COL_YELLOW;
         3'd2:    c = COL_CYAN;
         3'd3:    c = COL_GREEN;
         3'd4:    c = COL_MAGENTA;
         3'd5:    c = COL_RED;
         3'd6:    c = COL_BLUE;
         default: c = COL_BLACK;
      endcase
      return c;
   endfunction

   // One axis of box motion. Result is {dir, pos}; dir=1 means moving up-count.
   // All arithmetic is 11 bits wide so pos+step+size cannot wrap.
   function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                             input logic       dir,
                                             input int         limit,
                                             input int         size,
                                             input int         stp);
      logic [10:0] pos_w;
      logic [10:0] lim_w;
      logic [10:0] size_w;
      logic [10:0] step_w;
      logic [10:0] nxt_w;
      logic        nxt_dir;
      pos_w  = {1'b0, pos};
      lim_w  = 11'(limit);
      size_w = 11'(size);
      step_w = 11'(stp);
      if (dir) begin
         if (pos_w + step_w + size_w > lim_w) begin
            nxt_w   = lim_w - size_w;
            nxt_dir = 1'b0;
         end else begin
            nxt_w   = pos_w + step_w;
            nxt_dir = 1'b1;
         end
      end else begin
         if (pos_w < step_w) begin
            nxt_w   = '0;
            nxt_dir = 1'b1;
         end else begin
            nxt_w   = pos_w - step_w;
            nxt_dir = 1'b0;
         end
      end
      return {nxt_dir, nxt_w[9:0]};
   endfunction

endpackage

// File: rtl/pattern_box_motion.sv
// Bouncing-box position: advances one step per frame event and reflects off
// the edges of the visible area.
module pattern_box_motion
   import video_pkg::*;
#(
   parameter int H_ACT  = H_ACTIVE,
   parameter int V_ACT  = V_ACTIVE,
   parameter int B_SIZE = BOX_SIZE,
   parameter int B_STEP = BOX_STEP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [9:0] bx,
   output logic [9:0] by
);

   logic       dir_x;
   logic       dir_y;
   logic [10:0] nxt_x;
   logic [10:0] nxt_y;

   always_comb begin
      nxt_x = axis_step(bx, dir_x, H_ACT, B_SIZE, B_STEP);
      nxt_y = axis_step(by, dir_y, V_ACT, B_SIZE, B_STEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bx    <= '0;
         by    <= '0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (step) begin
         bx    <= nxt_x[9:0];
         dir_x <= nxt_x[10];
         by    <= nxt_y[9:0];
         dir_y <= nxt_y[10];
      end
   end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern pixel source: bars, checkerboard, gradient and bouncing box,
// with a fixed two-cycle registered path from x/y to RGB.
module pattern_gen
   import video_pkg::*;
#(
   parameter int H_ACT   = H_ACTIVE,
   parameter int V_ACT   = V_ACTIVE,
   parameter int B_SIZE  = BOX_SIZE,
   parameter int B_STEP  = BOX_STEP,
   parameter int C_SHIFT = CHECK_SHIFT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [1:0] mode,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [7:0] frame_count
);

   localparam int BAR_W = H_ACT / 8;

   logic        frame_event;
   logic [9:0]  bx;
   logic [9:0]  by;
   mode_e       mode_q;

   logic        active_c;
   logic [2:0]  bar_c;
   logic        in_box_c;
   logic        check_c;

   logic        s1_valid;
   logic        s1_active;
   logic [2:0]  s1_bar;
   logic        s1_in_box;
   logic        s1_check;
   logic [7:0]  s1_grad_r;
   logic [7:0]  s1_grad_g;

   logic [23:0] pix_c;

   // First blanking line, column 0: exactly one cycle per frame.
   assign frame_event = (x == 10'd0) && (y == 10'(V_ACT));

   pattern_box_motion #(
      .H_ACT  (H_ACT),
      .V_ACT  (V_ACT),
      .B_SIZE (B_SIZE),
      .B_STEP (B_STEP)
   ) u_box (
      .clk  (clk),
      .rst  (rst),
      .step (frame_event),
      .bx   (bx),
      .by   (by)
   );

   // Stage 1 decode: bar index by comparator chain, box hit with 11-bit sums.
   always_comb begin
      active_c = ({1'b0, x} < 11'(H_ACT)) && ({1'b0, y} < 11'(V_ACT));
      bar_c    = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if ({1'b0, x} >= 11'(i * BAR_W)) bar_c = 3'(i);
      end
      in_box_c = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + 11'(B_SIZE)) &&
                 ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + 11'(B_SIZE));
      check_c  = x[C_SHIFT] ^ y[C_SHIFT];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_active <= 1'b0;
         s1_bar    <= '0;
         s1_in_box <= 1'b0;
         s1_check  <= 1'b0;
         s1_grad_r <= '0;
         s1_grad_g <= '0;
      end else begin
         s1_valid  <= 1'b1;
         s1_active <= active_c;
         s1_bar    <= bar_c;
         s1_in_box <= in_box_c;
         s1_check  <= check_c;
         s1_grad_r <= x[9:2];
         s1_grad_g <= y[8:1];
      end
   end

   // Mode and frame counter change only at the frame event, so a frame never mixes modes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= MODE_BARS;
         frame_count <= '0;
      end else if (frame_event) begin
         mode_q      <= mode_e'(mode);
         frame_count <= frame_count + 8'd1;
      end
   end

   always_comb begin
      pix_c = COL_BLACK;
      if (s1_valid && s1_active) begin
         case (mode_q)
            MODE_BARS:  pix_c = bar_colour(s1_bar);
            MODE_CHECK: pix_c = s1_check ? COL_WHITE : COL_BLACK;
            MODE_GRAD:  pix_c = {s1_grad_r, s1_grad_g, frame_count};
            MODE_BOX:   pix_c = s1_in_box ? COL_RED : COL_BOX_BG;
            default:    pix_c = COL_BLACK;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         red   <= pix_c[23:16];
         green <= pix_c[15:8];
         blue  <= pix_c[7:0];
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: reference pixel model feeding a
// two-deep expected queue that is compared against the registered RGB.
module tb_pattern_gen;

   logic       clk;
   logic       rst;
   logic [9:0] x;
   logic [9:0] y;
   logic [1:0] mode;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [7:0] frame_count;

   int checks = 0;
   int errors = 0;

   logic [23:0] exp_q[$];
   bit          en_q[$];
   string       tag_q[$];

   // Reference state
   int m_mode;
   int m_fc;
   int m_bx;
   int m_by;
   bit m_dx;
   bit m_dy;

   pattern_gen dut (
      .clk         (clk),
      .rst         (rst),
      .x           (x),
      .y           (y),
      .mode        (mode),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_count (frame_count)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_fc   = 0;
      m_bx   = 0;
      m_by   = 0;
      m_dx   = 1;
      m_dy   = 1;
      exp_q.delete();
      en_q.delete();
      tag_q.delete();
   endtask

   task automatic model_event();
      m_mode = int'(mode);
      m_fc   = (m_fc + 1) % 256;
      if (m_dx) begin
         if (m_bx + 2 + 32 > 640) begin m_bx = 608; m_dx = 0; end
         else m_bx = m_bx + 2;
      end else begin
         if (m_bx < 2) begin m_bx = 0; m_dx = 1; end
         else m_bx = m_bx - 2;
      end
      if (m_dy) begin
         if (m_by + 2 + 32 > 480) begin m_by = 448; m_dy = 0; end
         else m_by = m_by + 2;
      end else begin
         if (m_by < 2) begin m_by = 0; m_dy = 1; end
         else m_by = m_by - 2;
      end
   endtask

   function automatic logic [23:0] model_rgb(input int px, input int py);
      logic [9:0]  xv;
      logic [9:0]  yv;
      logic [23:0] c;
      xv = px[9:0];
      yv = py[9:0];
      c  = 24'h000000;
      if (px < 640 && py < 480) begin
         case (m_mode)
            0: case (px / 80)
                  0: c = 24'hFFFFFF;
                  1: c = 24'hFFFF00;
                  2: c = 24'h00FFFF;
                  3: c = 24'h00FF00;
                  4: c = 24'hFF00FF;
                  5: c = 24'hFF0000;
                  6: c = 24'h0000FF;
                  default: c = 24'h000000;
               endcase
            1: c = (xv[5] ^ yv[5]) ? 24'hFFFFFF : 24'h000000;
            2: c = {xv[9:2], yv[8:1], 8'(m_fc)};
            default: c = (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32)
                         ? 24'hFF0000 : 24'h000040;
         endcase
      end
      return c;
   endfunction

   // driver: one pixel per clock; the entry pushed one call earlier is due now
   task automatic pix(input int px, input int py, input bit en, input string tag);
      logic [23:0] e;
      bit          e_en;
      string       e_tag;
      x = px[9:0];
      y = py[9:0];
      exp_q.push_back(model_rgb(px, py));
      en_q.push_back(en);
      tag_q.push_back(tag);
      if (px == 0 && py == 480) model_event();
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
         e     = exp_q.pop_front();
         e_en  = en_q.pop_front();
         e_tag = tag_q.pop_front();
         if (e_en) check(e_tag, {8'h00, red, green, blue}, {8'h00, e});
      end
   endtask

   task automatic flush();
      pix(700, 500, 0, "");
      pix(700, 500, 0, "");
   endtask

   task automatic frame_evt();
      pix(0, 480, 0, "");
   endtask

   task automatic box_probe(input string tag);
      if (m_bx > 0) pix(m_bx - 1, m_by, 1, {tag, "_left_out"});
      pix(m_bx,      m_by,      1, {tag, "_left_in"});
      pix(m_bx + 31, m_by + 31, 1, {tag, "_corner_in"});
      pix(m_bx + 32, m_by,      1, {tag, "_right_out"});
      pix(m_bx,      m_by + 32, 1, {tag, "_bottom_out"});
      flush();
   endtask

   initial begin
      int guard;
      rst  = 1'b1;
      x    = '0;
      y    = '0;
      mode = 2'd0;
      model_reset();
      #1;
      check("reset_rgb", {8'h00, red, green, blue}, 32'h0);
      check("reset_fc", {24'h0, frame_count}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // bars and their boundaries
      pix(0, 0, 1, "bars_x0");
      pix(79, 0, 1, "bars_x79");
      pix(80, 0, 1, "bars_x80");
      pix(559, 10, 1, "bars_x559");
      pix(560, 10, 1, "bars_x560");
      pix(640, 10, 1, "bars_blank_x");
      pix(100, 480, 1, "bars_blank_y");
      for (int i = 0; i < 8; i++) pix($urandom_range(0, 639), $urandom_range(0, 479), 1, "bars_rand");
      flush();

      // checker
      mode = 2'd1;
      frame_evt();
      check("fc_after_evt1", {24'h0, frame_count}, 32'(m_fc));
      pix(31, 0, 1, "chk_31_0");
      pix(32, 0, 1, "chk_32_0");
      pix(32, 32, 1, "chk_32_32");
      pix(639, 479, 1, "chk_corner");
      flush();

      // mode latch: change mid-frame stays bars until next event
      mode = 2'd0;
      frame_evt();
      pix(100, 50, 1, "latch_bars_y50");
      mode = 2'd1;
      pix(100, 100, 1, "latch_bars_y100");
      pix(32, 300, 1, "latch_bars_y300");
      pix(0, 479, 1, "latch_bars_y479");
      flush();
      check("latch_fc_before", {24'h0, frame_count}, 32'(m_fc));
      frame_evt();
      pix(500, 480, 0, "");
      pix(1, 480, 0, "");
      check("latch_fc_once", {24'h0, frame_count}, 32'(m_fc));
      pix(32, 0, 1, "latch_chk_y0");
      pix(0, 0, 1, "latch_chk_origin");
      flush();

      // gradient
      mode = 2'd2;
      frame_evt();
      for (int i = 0; i < 6; i++) pix($urandom_range(0, 639), $urandom_range(0, 479), 1, "grad_rand");
      pix(700, 10, 1, "grad_blank");
      flush();

      // box: run until bx=606 moving right, then watch the bounce
      mode = 2'd3;
      guard = 0;
      while (!(m_bx == 606 && m_dx == 1) && guard < 1000) begin
         frame_evt();
         guard++;
      end
      check("box_reach_606", 32'(guard < 1000), 32'd1);
      box_probe("box_606");
      frame_evt();
      box_probe("box_608a");
      frame_evt();
      box_probe("box_608b");
      frame_evt();
      box_probe("box_606back");
      pix(607, m_by, 1, "box_607_in");
      flush();

      // wrap of frame_count after 256 events from reset, in gradient mode
      guard = 0;
      while (m_fc != 255 && guard < 1000) begin
         frame_evt();
         guard++;
      end
      mode = 2'd2;
      frame_evt();
      check("fc_wrap", {24'h0, frame_count}, 32'(m_fc));
      check("fc_wrap_zero", {24'h0, frame_count}, 32'h0);
      pix(10, 5, 1, "grad_wrap");
      pix(11, 5, 0, "");

      // reset mid-line clears outputs immediately
      rst = 1'b1;
      #1;
      check("midrst_rgb", {8'h00, red, green, blue}, 32'h0);
      check("midrst_fc", {24'h0, frame_count}, 32'h0);
      model_reset();
      #1;
      rst = 1'b0;
      pix(0, 0, 1, "postrst_bars");
      pix(85, 0, 1, "postrst_bars2");
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
